interlock_input_conditioner: RTL

Front-end conditioning stage for the airlock interlock controller. Synchronizes the four slide switches (SW0–SW3) and the three active-low push-buttons (Key0–Key2) to `Clock`, then debounces every channel. It drives clean switch levels, active-high key-held levels and single-cycle key-press pulses straight into the interlock state machine, which consumes only these conditioned signals and never the raw pins.

---
 rtl/interlock_input_conditioner.sv | 121 ++++++++++++
 1 files changed

// File: rtl/interlock_input_conditioner.sv
// Input conditioning for the airlock interlock: synchronizes and debounces four
// switches and three active-low keys, and produces key-held levels and press pulses.

module interlock_debounce_chan #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_W           = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      // Any sample agreeing with the accepted level restarts the qualification window.
      if (s2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = s2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      rise_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;

endmodule

module interlock_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_W           = 4
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       SW0,
   input  logic       SW1,
   input  logic       SW2,
   input  logic       SW3,
   input  logic       Key0,
   input  logic       Key1,
   input  logic       Key2,
   output logic [3:0] SwStable,
   output logic [2:0] KeyHeld,
   output logic [2:0] KeyPress
);

   localparam int NUM_SW  = 4;
   localparam int NUM_KEY = 3;
   localparam int NUM_CH  = NUM_SW + NUM_KEY;

   // Keys are inverted at entry so every channel idles at 0 and 1 means active.
   logic [NUM_CH-1:0]  raw_in;
   logic [NUM_CH-1:0]  stable_all;
   logic [NUM_SW-1:0]  sw_rise_unused;
   logic [NUM_KEY-1:0] key_rise;

   assign raw_in = {~Key2, ~Key1, ~Key0, SW3, SW2, SW1, SW0};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      if (i < NUM_SW) begin : g_sw
         interlock_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
         ) u_chan (
            .clk   (Clock),
            .rst   (Reset),
            .raw   (raw_in[i]),
            .stable(stable_all[i]),
            .rise  (sw_rise_unused[i])
         );
      end else begin : g_key
         interlock_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
         ) u_chan (
            .clk   (Clock),
            .rst   (Reset),
            .raw   (raw_in[i]),
            .stable(stable_all[i]),
            .rise  (key_rise[i-NUM_SW])
         );
      end
   end

   assign SwStable = stable_all[NUM_SW-1:0];
   assign KeyHeld  = stable_all[NUM_CH-1:NUM_SW];
   assign KeyPress = key_rise;

endmodule
